// File: rtl/mdu_seq.sv
// mdu_seq: iterative unsigned MUL/MULHU/DIVU/REMU sequencer issuing one ADD/SUB per cycle to an external ALU.
// Optional build macro MDU_FASTZERO_EN: zero operands skip iteration and go straight to DONE.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_out_i
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rs;
    logic             fast, carry, ge;

`ifdef MDU_FASTZERO_EN
    assign fast = (rs2_i == '0) || (!op_i[1] && rs1_i == '0);
`else
    assign fast = 1'b0;
`endif

    // Next-state, datapath update and ALU drive; HI/LO double as R/Q when dividing
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        m_d        = m_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        done_d     = 1'b0;
        alu_a_o    = '0;
        alu_b_o    = '0;
        alu_ctrl_o = 4'b0000;
        rs         = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        carry      = 1'b0;
        ge         = 1'b0;
        case (state_q)
            IDLE: begin
                // the cycle carrying the done pulse still refuses a new request
                if (start_i && !done_q) begin
                    op_d    = op_i;
                    cnt_d   = '0;
                    m_d     = op_i[1] ? rs2_i : rs1_i;
                    state_d = fast ? DONE : ITER;
                    hi_d    = (fast && op_i[1]) ? rs1_i : '0;
                    lo_d    = fast ? (op_i[1] ? '1 : '0) : (op_i[1] ? rs1_i : rs2_i);
                end
            end
            ITER: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : ITER;
                if (op_q[1]) begin
                    alu_a_o    = rs;
                    alu_b_o    = m_q;
                    alu_ctrl_o = 4'b0001;
                    ge         = hi_q[WIDTH-1] | (rs >= m_q);
                    hi_d       = ge ? alu_out_i : rs;
                    lo_d       = {lo_q[WIDTH-2:0], ge};
                end else begin
                    alu_a_o = hi_q;
                    alu_b_o = lo_q[0] ? m_q : '0;
                    carry   = alu_out_i < hi_q;
                    hi_d    = {carry, alu_out_i[WIDTH-1:1]};
                    lo_d    = {alu_out_i[0], lo_q[WIDTH-1:1]};
                end
            end
            DONE: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                result_d = op_q[0] ? hi_q : lo_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset clearing every register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = state_q != IDLE;
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and randomized checks of mdu_seq against an arithmetic reference model
module tb_mdu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, busy, done;
    logic [1:0]   op;
    logic [W-1:0] rs1, rs2, result, alu_a, alu_b, alu_out;
    logic [3:0]   alu_ctrl;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    assign alu_out = (alu_ctrl == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

    mdu_seq #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .busy_o(busy), .done_o(done), .result_o(result),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl), .alu_out_i(alu_out)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MDU_FASTZERO_EN
        return (b == '0) || (!o[1] && a == '0);
`else
        return (o == 2'b00) && (a == '0) && (b == '0) && 1'b0;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        int       dedge, seen, ndone, bad_busy, bad_alu;
        bit       fast;
        logic [3:0] ctl;
        fast     = is_fast(o, a, b);
        dedge    = fast ? 1 : W + 1;
        ctl      = o[1] ? 4'b0001 : 4'b0000;
        seen     = -1;
        ndone    = 0;
        bad_busy = 0;
        bad_alu  = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        for (int e = 0; e <= W + 4; e++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (seen < 0) seen = e;
            end
            if (busy !== (e < dedge)) bad_busy++;
            if (!fast && e < W) begin
                if (alu_ctrl !== ctl) bad_alu++;
            end else if (alu_ctrl !== 4'b0000 || alu_a !== '0 || alu_b !== '0) begin
                bad_alu++;
            end
            start = poke && ((e < dedge && (e == 5 || e == 20)) || e == dedge);
            op    = 2'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
        end
        start = 1'b0;
        check({tag, "_result"}, result, model(o, a, b));
        check({tag, "_done_edge"}, W'(seen), W'(dedge));
        check({tag, "_done_count"}, W'(ndone), W'(1));
        check({tag, "_busy"}, W'(bad_busy), '0);
        check({tag, "_alu"}, W'(bad_alu), '0);
    endtask

    initial begin
        int ndone;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_result", result, '0);
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_b", alu_b, '0);
        check("rst_alu_ctrl", W'(alu_ctrl), '0);
        reset = 1'b0;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 1'b0);
        run_op("mulhu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_ones", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        run_op("divu_msb_3", 2'b10, 32'h8000_0000, 32'd3, 1'b0);
        run_op("remu_msb_3", 2'b11, 32'h8000_0000, 32'd3, 1'b0);
        run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 1'b0);
        run_op("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 1'b0);
        run_op("mulhu_zero", 2'b01, 32'd0, 32'hDEAD_BEEF, 1'b0);
        run_op("divu_zero_dividend", 2'b10, 32'd0, 32'd9, 1'b0);
        run_op("mul_3x5_poke", 2'b00, 32'd3, 32'd5, 1'b1);

        @(negedge clk);
        start = 1'b1; op = 2'b10; rs1 = $urandom; rs2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        check("abort_result", result, '0);
        check("abort_alu_a", alu_a, '0);
        check("abort_alu_b", alu_b, '0);
        check("abort_alu_ctrl", W'(alu_ctrl), '0);
        ndone = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", W'(ndone), '0);
        run_op("divu_9_2", 2'b10, 32'd9, 32'd2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 300)) : $urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 300)) : $urandom);
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
